// File: rtl/audio_pkg.sv
// Shared types for the audio sample FIFO.
// The optional event counters in audio_sample_fifo are enabled by AUDIO_FIFO_STATS_EN.
package audio_pkg;

  localparam int SAMPLE_W = 32;
  localparam int CNT_W    = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  // FILL waits for the prime level before playback; RUN pops on every request.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } fifo_state_e;

  // Saturating increment so a long-running stream never wraps a statistic to zero.
  function automatic cnt_t sat_inc(input cnt_t value);
    if (value == {CNT_W{1'b1}}) begin
      return value;
    end
    return value + cnt_t'(1);
  endfunction

endpackage

// File: rtl/strobe_edge_det.sv
// Registered rising-edge detector for a codec sample strobe.
// A strobe that is already high while reset is released stays disarmed
// until it has been seen low, so it cannot fake an event.
module strobe_edge_det (
  input  logic clk_i,
  input  logic reset_i,
  input  logic stb_i,
  output logic evt_o
);

  logic stb_q;
  logic stb_d;
  logic armed_q;
  logic armed_d;

  // Next-state for the delayed strobe and the arm flag; reset captures whether the strobe is low.
  always_comb begin
    stb_d   = stb_i;
    armed_d = armed_q | ~stb_i;
    if (reset_i) begin
      stb_d   = 1'b0;
      armed_d = ~stb_i;
    end
  end

  // Edge-detect state registers.
  always_ff @(posedge clk_i) begin
    stb_q   <= stb_d;
    armed_q <= armed_d;
  end

  assign evt_o = stb_i & ~stb_q & armed_q;

endmodule

// File: rtl/audio_sample_fifo.sv
// Elastic sample buffer between an RX codec and a TX codec on one clock.
// Playback starts once PRIME samples are buffered and drops back to FILL on underflow.
// Define AUDIO_FIFO_STATS_EN to enable the saturating overflow/underflow counters.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PRIME = DEPTH / 2
) (
  input  logic                     lmmi_clk_i,
  input  logic                     reset_i,
  input  logic                     wr_stb_i,
  input  sample_t                  wr_dat_i,
  input  logic                     rd_stb_i,
  output sample_t                  rd_dat_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     run_o,
  output logic                     ovf_o,
  output logic                     udf_o,
  input  logic                     clr_flags_i,
  output logic [15:0]              ovf_cnt_o,
  output logic [15:0]              udf_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME);

  logic wr_evt;
  logic rd_evt;

  strobe_edge_det u_wr_edge (
    .clk_i   (lmmi_clk_i),
    .reset_i (reset_i),
    .stb_i   (wr_stb_i),
    .evt_o   (wr_evt)
  );

  strobe_edge_det u_rd_edge (
    .clk_i   (lmmi_clk_i),
    .reset_i (reset_i),
    .stb_i   (rd_stb_i),
    .evt_o   (rd_evt)
  );

  sample_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  fifo_state_e   state_q, state_d;
  sample_t       rd_dat_q, rd_dat_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic full;
  logic empty;
  logic in_run;
  logic pop;
  logic do_wr;
  logic ovf_evt;
  logic udf_evt;

  // Classify this cycle's strobe events into pop, store, overflow and underflow.
  always_comb begin
    full    = (level_q == DEPTH_LVL);
    empty   = (level_q == '0);
    in_run  = (state_q == ST_RUN);
    pop     = in_run & rd_evt & ~empty;
    udf_evt = in_run & rd_evt & empty;
    ovf_evt = wr_evt & full & ~pop;
    do_wr   = wr_evt & ~ovf_evt;
  end

  // Pointer, level, output sample and flag updates for the next cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rd_dat_d = rd_dat_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({do_wr, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (rd_evt && !in_run) begin
      rd_dat_d = '0;
    end else if (pop) begin
      rd_dat_d = mem_q[rd_ptr_q];
    end

    if (clr_flags_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (ovf_evt) begin
      ovf_d = 1'b1;
    end
    if (udf_evt) begin
      udf_d = 1'b1;
    end
  end

  // Playback state: enter RUN once primed, fall back to FILL on underflow.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (level_d >= PRIME_LVL) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (udf_evt) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge lmmi_clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= ST_FILL;
      rd_dat_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      rd_dat_q <= rd_dat_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Sample storage; contents are left as-is on reset since the pointers define validity.
  always_ff @(posedge lmmi_clk_i) begin
    if (!reset_i && do_wr) begin
      mem_q[wr_ptr_q] <= wr_dat_i;
    end
  end

`ifdef AUDIO_FIFO_STATS_EN
  cnt_t ovf_cnt_q, ovf_cnt_d;
  cnt_t udf_cnt_q, udf_cnt_d;

  // Saturating event counts, unaffected by the flag clear.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    udf_cnt_d = udf_cnt_q;
    if (ovf_evt) begin
      ovf_cnt_d = sat_inc(ovf_cnt_q);
    end
    if (udf_evt) begin
      udf_cnt_d = sat_inc(udf_cnt_q);
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge lmmi_clk_i) begin
    if (reset_i) begin
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      udf_cnt_q <= udf_cnt_d;
    end
  end

  assign ovf_cnt_o = ovf_cnt_q;
  assign udf_cnt_o = udf_cnt_q;
`else
  assign ovf_cnt_o = '0;
  assign udf_cnt_o = '0;
`endif

  assign rd_dat_o = rd_dat_q;
  assign level_o  = level_q;
  assign full_o   = full;
  assign empty_o  = empty;
  assign run_o    = in_run;
  assign ovf_o    = ovf_q;
  assign udf_o    = udf_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo (DEPTH=8, PRIME=4).
// Counter expectations follow AUDIO_FIFO_STATS_EN when it is defined for the build.
module tb_audio_sample_fifo;

`ifdef AUDIO_FIFO_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_stb = 1'b0;
  logic [31:0] wr_dat = '0;
  logic        rd_stb = 1'b0;
  logic        clr_flags = 1'b0;
  logic [31:0] rd_dat;
  logic [3:0]  level;
  logic        full, empty, run, ovf, udf;
  logic [15:0] ovf_cnt, udf_cnt;

  int checks = 0;
  int failures = 0;

  audio_sample_fifo #(.DEPTH(8), .PRIME(4)) dut (
    .lmmi_clk_i  (clk),
    .reset_i     (reset),
    .wr_stb_i    (wr_stb),
    .wr_dat_i    (wr_dat),
    .rd_stb_i    (rd_stb),
    .rd_dat_o    (rd_dat),
    .level_o     (level),
    .full_o      (full),
    .empty_o     (empty),
    .run_o       (run),
    .ovf_o       (ovf),
    .udf_o       (udf),
    .clr_flags_i (clr_flags),
    .ovf_cnt_o   (ovf_cnt),
    .udf_cnt_o   (udf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic        clr;
    logic [31:0] wdat;
    logic [3:0]  lvl;
    logic [31:0] rdat;
    logic        run;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic wr, input logic rd, input logic clr, input logic [31:0] wdat,
                        input logic [3:0] lvl, input logic [31:0] rdat, input logic run_e,
                        input logic full_e, input logic empty_e, input logic ovf_e, input logic udf_e);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.wdat = wdat;
    v.lvl = lvl; v.rdat = rdat; v.run = run_e; v.full = full_e;
    v.empty = empty_e; v.ovf = ovf_e; v.udf = udf_e;
    vecs.push_back(v);
  endtask

  // One strobe pulse: high for one cycle, low again; outputs are sampled on the falling edge after.
  task automatic applyStimulus(input logic wr, input logic rd, input logic clr, input logic [31:0] wdat);
    @(negedge clk);
    wr_stb    = wr;
    rd_stb    = rd;
    clr_flags = clr;
    wr_dat    = wdat;
    @(negedge clk);
    wr_stb    = 1'b0;
    rd_stb    = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkRow(input string tag, input vec_t v);
    checkOutput({tag, "_level"}, 32'(level), 32'(v.lvl));
    checkOutput({tag, "_rd_dat"}, rd_dat, v.rdat);
    checkOutput({tag, "_run"}, 32'(run), 32'(v.run));
    checkOutput({tag, "_full"}, 32'(full), 32'(v.full));
    checkOutput({tag, "_empty"}, 32'(empty), 32'(v.empty));
    checkOutput({tag, "_ovf"}, 32'(ovf), 32'(v.ovf));
    checkOutput({tag, "_udf"}, 32'(udf), 32'(v.udf));
  endtask

  initial begin
    vec_t v;

    // Prime with samples 1..4, drain them, then underflow once in RUN.
    for (int i = 1; i <= 4; i++)
      addVec(1, 0, 0, 32'(i), 4'(i), 32'h0, (i == 4), 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      addVec(0, 1, 0, 32'h0, 4'(4 - i), 32'(i), 1, 0, (i == 4), 0, 0);
    addVec(0, 1, 0, 32'h0, 4'd0, 32'd4, 0, 0, 1, 0, 1);
    addVec(0, 0, 1, 32'h0, 4'd0, 32'd4, 0, 0, 1, 0, 0);
    addVec(0, 1, 0, 32'h0, 4'd0, 32'd0, 0, 0, 1, 0, 0);
    // Nine writes into an eight-entry FIFO, then read all eight back.
    for (int i = 1; i <= 9; i++)
      addVec(1, 0, 0, 32'hA0 + 32'(i), (i > 8) ? 4'd8 : 4'(i), 32'h0, (i >= 4),
             (i >= 8), 0, (i == 9), 0);
    for (int i = 1; i <= 8; i++)
      addVec(0, 1, 0, 32'h0, 4'(8 - i), 32'hA0 + 32'(i), 1, 0, (i == 8), 1, 0);
    addVec(0, 0, 1, 32'h0, 4'd0, 32'hA8, 1, 0, 1, 0, 0);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    v = '{wr:0, rd:0, clr:0, wdat:0, lvl:0, rdat:0, run:0, full:0, empty:1, ovf:0, udf:0};
    checkRow("reset", v);
    checkOutput("reset_ovf_cnt", 32'(ovf_cnt), 32'd0);
    checkOutput("reset_udf_cnt", 32'(udf_cnt), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].wdat);
      checkRow($sformatf("row%0d", i), vecs[i]);
    end
    checkOutput("table_ovf_cnt", 32'(ovf_cnt), 32'(STATS));
    checkOutput("table_udf_cnt", 32'(udf_cnt), 32'(STATS));

    // Held-high read strobe is a single pop.
    for (int i = 1; i <= 4; i++) applyStimulus(1, 0, 0, 32'hB0 + 32'(i));
    checkOutput("b_level", 32'(level), 32'd4);
    @(negedge clk);
    rd_stb = 1'b1;
    repeat (10) @(negedge clk);
    rd_stb = 1'b0;
    checkOutput("held_rd_level", 32'(level), 32'd3);
    checkOutput("held_rd_dat", rd_dat, 32'hB1);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("rearm_rd_dat", rd_dat, 32'hB2);
    checkOutput("rearm_level", 32'(level), 32'd2);

    // Simultaneous write and read while full.
    for (int i = 1; i <= 6; i++) applyStimulus(1, 0, 0, 32'hC0 + 32'(i));
    checkOutput("c_full", 32'(full), 32'd1);
    applyStimulus(1, 1, 0, 32'hC7);
    checkOutput("wr_rd_full_level", 32'(level), 32'd8);
    checkOutput("wr_rd_full_ovf", 32'(ovf), 32'd0);
    checkOutput("wr_rd_full_dat", rd_dat, 32'hB3);
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("after_full_dat", rd_dat, 32'hB4);
    checkOutput("after_full_level", 32'(level), 32'd7);

    // Overflow in the same cycle as a flag clear keeps the flag set.
    applyStimulus(1, 0, 0, 32'hD1);
    applyStimulus(1, 0, 1, 32'hD2);
    checkOutput("set_wins_ovf", 32'(ovf), 32'd1);
    checkOutput("set_wins_level", 32'(level), 32'd8);
    checkOutput("d_ovf_cnt", 32'(ovf_cnt), 32'(2 * STATS));
    applyStimulus(0, 0, 1, 32'h0);
    checkOutput("clr_ovf", 32'(ovf), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 1, 0, 32'h0);
      checkOutput($sformatf("pop_c%0d", i), rd_dat, 32'hC0 + 32'(i));
    end
    checkOutput("pre_reset_level", 32'(level), 32'd5);

    // Reset mid-stream with both strobes held high across release.
    @(negedge clk);
    reset  = 1'b1;
    wr_stb = 1'b1;
    rd_stb = 1'b1;
    wr_dat = 32'hFF;
    @(negedge clk);
    reset = 1'b0;
    v = '{wr:0, rd:0, clr:0, wdat:0, lvl:0, rdat:0, run:0, full:0, empty:1, ovf:0, udf:0};
    checkRow("mid_reset", v);
    checkOutput("mid_reset_ovf_cnt", 32'(ovf_cnt), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("held_across_reset_level", 32'(level), 32'd0);
    wr_stb = 1'b0;
    rd_stb = 1'b0;
    applyStimulus(1, 0, 0, 32'hE1);
    checkOutput("first_after_reset_level", 32'(level), 32'd1);
    checkOutput("first_after_reset_run", 32'(run), 32'd0);

    // Underflow with a same-cycle write stores the write and returns to FILL.
    for (int i = 2; i <= 4; i++) applyStimulus(1, 0, 0, 32'hE0 + 32'(i));
    checkOutput("e_run", 32'(run), 32'd1);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 0, 32'h0);
    checkOutput("e_drain_dat", rd_dat, 32'hE4);
    applyStimulus(1, 1, 0, 32'hF1);
    checkOutput("udf_wr_level", 32'(level), 32'd1);
    checkOutput("udf_wr_udf", 32'(udf), 32'd1);
    checkOutput("udf_wr_run", 32'(run), 32'd0);
    checkOutput("udf_wr_dat", rd_dat, 32'hE4);
    checkOutput("udf_wr_cnt", 32'(udf_cnt), 32'(STATS));
    applyStimulus(0, 1, 0, 32'h0);
    checkOutput("fill_rd_dat", rd_dat, 32'h0);
    checkOutput("fill_rd_level", 32'(level), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_sample_fifo.md
AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

Interface
REQ-001 Parameter DEPTH, default 8, sample storage entries; power of two, 4..64.
REQ-002 Parameter PRIME, default DEPTH/2, fill level that starts playback; 1..DEPTH.
REQ-003 lmmi_clk_i  in  1  sole clock; all logic on rising edge.
REQ-004 reset_i  in  1  synchronous, active-high reset.
REQ-005 wr_stb_i  in  1  receive-side sample strobe (RX codec mem_rdwr_o); level or pulse.
REQ-006 wr_dat_i  in  32  packed stereo sample {L[31:16], R[15:0]} from the RX codec.
REQ-007 rd_stb_i  in  1  transmit-side sample request (TX codec mem_rdwr_o); level or pulse.
REQ-008 rd_dat_o  out  32  sample presented to the TX codec sample_dat_i.
REQ-009 level_o  out  $clog2(DEPTH)+1  current occupancy.
REQ-010 full_o / empty_o  out  1  level_o==DEPTH / level_o==0.
REQ-011 run_o  out  1  high in state RUN.
REQ-012 ovf_o / udf_o  out  1  sticky overflow / underflow flags.
REQ-013 clr_flags_i  in  1  clears ovf_o and udf_o.
REQ-014 ovf_cnt_o / udf_cnt_o  out  16  event counters (see Configuration).

Function
REQ-015 Write event = rising edge of wr_stb_i (wr_stb_i & ~registered wr_stb_i); read event likewise on rd_stb_i; a held-high strobe is exactly one event.
REQ-016 A write event when not full stores wr_dat_i at the write pointer in the detection cycle; the pointer wraps DEPTH-1 -> 0.
REQ-017 A write event when full, with no same-cycle read event, drops the sample and sets ovf_o; stored data unchanged.
REQ-018 States: FILL (reset state), RUN.
REQ-019 FILL: read events pop nothing; rd_dat_o loads 0; FILL -> RUN when post-update level_o >= PRIME.
REQ-020 RUN, read event, not empty: rd_dat_o loads the oldest entry, read pointer advances (wrapping); rd_dat_o valid the cycle after detection.
REQ-021 RUN, read event, empty: underflow; rd_dat_o holds previous value; udf_o set; next state FILL.
REQ-022 Same-cycle write+read when full in RUN: both occur, level unchanged, no overflow.
REQ-023 Same-cycle write+read when empty in RUN: underflow per REQ-021 and the write is still stored (level becomes 1).
REQ-024 level_o updates the cycle after the event(s): +1 write, -1 pop, unchanged for both.
REQ-025 clr_flags_i clears the sticky flags; a same-cycle set event wins.

Reset
REQ-026 reset_i high at a rising edge: pointers 0, level_o 0, empty_o 1, full_o 0, run_o 0, state FILL, rd_dat_o 0, ovf_o/udf_o 0, counters 0, strobe edge registers 0.
REQ-027 Reset mid-operation discards all stored samples; storage array need not be cleared.
REQ-028 A strobe held high across reset deassertion produces no event until it falls and rises again.

Configuration
REQ-029 Macro AUDIO_FIFO_STATS_EN defined: ovf_cnt_o/udf_cnt_o increment once per overflow/underflow event, saturate at 16'hFFFF, clear only on reset.
REQ-030 Macro not defined: ports retained, driven constant 0, no counter logic.

Structure
REQ-031 Package audio_pkg holds SAMPLE_W=32, typedef sample_t (logic [SAMPLE_W-1:0]) and the FILL/RUN state enum.
REQ-032 Sub-module strobe_edge_det (one registered rising-edge detector) instantiated for wr_stb_i and rd_stb_i.

Verification
REQ-033 Reset, then 4 writes (1..4), DEPTH=8, PRIME=4 -> run_o rises after 4th write; 4 reads -> rd_dat_o 1,2,3,4, empty_o=1.
REQ-034 9 writes with no reads -> level_o=8, full_o=1, ovf_o=1, 9th sample absent from read-back.
REQ-035 In RUN with empty FIFO, read event -> rd_dat_o holds last value, udf_o=1, run_o=0, counter=1 with AUDIO_FIFO_STATS_EN.
REQ-036 rd_stb_i held high 10 cycles -> exactly one pop; simultaneous write+read when full -> level_o stays 8, ovf_o=0.
REQ-037 Reset asserted with level_o=5 -> next cycle level_o=0, empty_o=1, rd_dat_o=0, state FILL.
